antilog2_arbiter: RTL and testbench
===================================

# antilog2_arbiter

Shares one AntiLog2 core (12-bit log input with 6 integer and 6 fractional bits; output is the integer part of 2^x truncated to DOUT_WIDTH bits; 2-cycle latency; no enable or reset) among N_REQ requesters. The block arbitrates round-robin and tags each issue through the core pipeline. Results are buffered in a small output FIFO, with a credit check so that nothing is ever dropped under backpressure. It sits between the per-channel log-domain gain stages and the linear-domain consumers.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- DOUT_WIDTH, 8: result width, passed to the core's DOUT_WIDTH.
- FIFO_DEPTH, 4: output FIFO entries, minimum 2. A value ≥4 sustains one issue per cycle.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- REQ_VALID  in  N_REQ  per-requester request valid.
- REQ_DATA  in  12*N_REQ  requester i occupies bits [12i+11:12i], format xxxxxx.yyyyyy.
- REQ_READY  out  N_REQ  one-hot or zero grant.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts result.
- RES_DATA  out  DOUT_WIDTH  anti-log result.
- RES_ID  out  $clog2(N_REQ)  index of the originating requester.
- RES_SAT  out  1  result was saturated (see Configuration).
- BUSY  out  1  any tag in flight or FIFO non-empty.

## Operation
- Issue condition: credit_ok = (fifo_count + inflight) < FIFO_DEPTH, using registered counts only. A pop in the same cycle earns no credit.
- Grant:
  - Round-robin starting at ptr+1 mod N_REQ.
  - REQ_READY[i] = credit_ok & (i is the first requester with REQ_VALID set from that start point).
  - REQ_READY may depend combinationally on REQ_VALID.
- Issue is REQ_VALID[i] & REQ_READY[i].
  - The core DIN is driven with REQ_DATA[i].
  - ptr updates to i at the clock edge.
  - When there is no issue, DIN holds 0 and ptr holds.
- Tag pipeline: 2 stages of {valid, id, sat}, aligned to the core latency. The core is free-running, so its output is qualified only by the stage-2 tag valid.
- FIFO write: when the stage-2 tag is valid, push {DOUT, id, sat}. The credit check makes a push to a full FIFO impossible; an assertion checks this.
- FIFO read: the head drives RES_*. Pop when RES_VALID & RES_READY.
- fifo_count: push and pop in the same cycle leave it unchanged. It wraps never; range is 0..FIFO_DEPTH.
- inflight: number of valid tags in the 2 stages, range 0..2.
- Requests are served in issue order; results for the same id never reorder.
- Reset values after rst:
  - REQ_READY = 0 while rst is high.
  - RES_VALID = 0, RES_DATA = 0, RES_ID = 0, RES_SAT = 0, BUSY = 0.
  - ptr = N_REQ-1, so requester 0 has first priority.
  - All tags invalid and FIFO empty.
- Reset mid-operation: in-flight and buffered results are discarded. The core's internal registers are don't-care because the tags are cleared.

## Timing
- Issue in cycle t → core output valid in cycle t+2 → FIFO write at the edge ending t+2 → RES_VALID high from t+3 at the earliest. Issue-to-result latency is 3 cycles.
- Throughput is 1 issue per cycle when FIFO_DEPTH ≥ 4 and RES_READY is held high.
- With RES_READY low, at most FIFO_DEPTH results are outstanding. Grants stop when fifo_count + inflight reaches FIFO_DEPTH.
- RES_* stay stable while RES_VALID & !RES_READY.

## Configuration
- ANTILOG2_ARB_SAT_EN defined:
  - At issue, the block computes sat = (DIN[11:6] ≥ DOUT_WIDTH).
  - A saturated entry returns RES_DATA = all ones and RES_SAT = 1.
- ANTILOG2_ARB_SAT_EN undefined:
  - RES_DATA is the raw truncated core output.
  - RES_SAT is tied to 0 and the sat tag bit is removed.

## Structure
- antilog2_pkg holds:
  - LOG_W = 12, LOG_FRAC_W = 6, CORE_LATENCY = 2.
  - Tag type {valid, id, sat}.
  - Helper function for the id width.
- Sub-module antilog2_rr_grant is the combinational round-robin priority encoder. Inputs are req and ptr; outputs are grant one-hot and grant index.
- The core is instantiated once, with DOUT_WIDTH passed through.

## Test plan
- Single request, requester 2, DIN=0x000, RES_READY=1 → RES_VALID 3 cycles after issue, RES_DATA=1, RES_ID=2.
- All 4 requesters hold valid, with DIN 0x040/0x0A0/0x080/0x1C0 → grants in order 0,1,2,3,0,… one per cycle; results 2, 5, 4, 128 with matching RES_ID.
- RES_READY=0 with continuous requests → exactly 4 grants, then REQ_READY stays 0. After RES_READY=1, the results drain in order, with no loss and no duplicates.
- DIN=0x200, DOUT_WIDTH=8 → result 0 with RES_SAT=0 when SAT_EN is undefined; result 255 with RES_SAT=1 when SAT_EN is defined.
- Assert rst for 1 cycle with 2 tags in flight and 2 entries in the FIFO → all outputs at reset values the next cycle, no stale RES_VALID, next grant goes to requester 0.
- Push and pop in the same cycle with the FIFO at FIFO_DEPTH-1 → count is unchanged and there is no overflow assertion.

Source files
------------

// File: rtl/antilog2_pkg.sv
// Shared constants, tag type and helpers for the antilog2 arbiter slice.
// ANTILOG2_ARB_SAT_EN adds a saturation bit to the tag.
package antilog2_pkg;
    localparam int LOG_W        = 12;
    localparam int LOG_FRAC_W   = 6;
    localparam int CORE_LATENCY = 2;
    localparam int ID_MAX_W     = 4;    // enough for 16 requesters

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
`ifdef ANTILOG2_ARB_SAT_EN
        logic                sat;
`endif
    } tag_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/antilog2.sv
// AntiLog2 core: dout = floor(2^din) truncated to DOUT_WIDTH, din is 6.6 fixed point.
// Two register stages, no enable or reset.
module antilog2
    import antilog2_pkg::*;
#(
    parameter int DOUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [LOG_W-1:0]      din,
    output logic [DOUT_WIDTH-1:0] dout
);
    localparam int MW     = 17;                      // Q1.16 mantissa
    localparam int INT_W  = LOG_W - LOG_FRAC_W;
    localparam int FULL_W = MW + (1 << INT_W) + DOUT_WIDTH;

    // 2^(2^b/64) in Q1.16; the fraction is the product over its set bits
    localparam logic [MW-1:0] ROOT [0:LOG_FRAC_W-1] = '{
        17'd66250, 17'd66971, 17'd68438, 17'd71468, 17'd77935, 17'd92682
    };

    logic [MW-1:0]    mant;
    logic [MW-1:0]    mant_q;
    logic [INT_W-1:0] int_q;

    always_comb begin
        mant = 17'd65536;
        for (int b = 0; b < LOG_FRAC_W; b++) begin
            if (din[b])
                mant = MW'((({17'b0, mant} * {17'b0, ROOT[b]}) + 34'd32768) >> 16);
        end
    end

    always_ff @(posedge clk) begin
        mant_q <= mant;
        int_q  <= din[LOG_W-1:LOG_FRAC_W];
        dout   <= DOUT_WIDTH'((FULL_W'(mant_q) << int_q) >> 16);
    end
endmodule

// File: rtl/antilog2_rr_grant.sv
// Combinational round-robin priority encoder: search starts at ptr+1 mod N.
module antilog2_rr_grant #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);
    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/antilog2_arbiter.sv
// Round-robin share of one AntiLog2 core with tagged pipeline and credit-checked result FIFO.
// ANTILOG2_ARB_SAT_EN: saturate results whose integer part reaches DOUT_WIDTH.
module antilog2_arbiter
    import antilog2_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DOUT_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         REQ_VALID,
    input  logic [LOG_W*N_REQ-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]         REQ_READY,
    output logic                     RES_VALID,
    input  logic                     RES_READY,
    output logic [DOUT_WIDTH-1:0]    RES_DATA,
    output logic [$clog2(N_REQ)-1:0] RES_ID,
    output logic                     RES_SAT,
    output logic                     BUSY
);
    localparam int IDW = id_width(N_REQ);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DOUT_WIDTH-1:0] data;
        logic [IDW-1:0]        id;
`ifdef ANTILOG2_ARB_SAT_EN
        logic                  sat;
`endif
    } entry_t;

    logic [IDW-1:0]        ptr;
    logic [N_REQ-1:0]      gnt;
    logic [IDW-1:0]        gidx;
    logic                  credit_ok;
    logic                  issue;
    logic [LOG_W-1:0]      din;
    logic [DOUT_WIDTH-1:0] core_dout;
    tag_t                  tag_in;
    tag_t                  tag_q [1:CORE_LATENCY];
    logic [1:0]            inflight;
    entry_t                mem [FIFO_DEPTH];
    entry_t                push_entry;
    entry_t                head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic                  push, pop;
    logic [ID_MAX_W-1:0]   unused_tag_id;

    antilog2_rr_grant #(.N(N_REQ), .IDW(IDW)) u_grant (
        .req (REQ_VALID),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    // Credit uses registered counts only, so a same-cycle pop frees nothing
    assign inflight  = {1'b0, tag_q[1].valid} + {1'b0, tag_q[CORE_LATENCY].valid};
    assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight)) < DEPTH_C;
    assign REQ_READY = (credit_ok && !rst) ? gnt : '0;
    assign issue     = |REQ_READY;

    always_comb begin
        din = '0;
        if (issue) din = REQ_DATA[LOG_W*int'(gidx) +: LOG_W];
    end

    antilog2 #(.DOUT_WIDTH(DOUT_WIDTH)) u_core (
        .clk  (clk),
        .din  (din),
        .dout (core_dout)
    );

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.id    = ID_MAX_W'(gidx);
`ifdef ANTILOG2_ARB_SAT_EN
        tag_in.sat   = issue && (int'(din[LOG_W-1:LOG_FRAC_W]) >= DOUT_WIDTH);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(N_REQ - 1);
            for (int s = 1; s <= CORE_LATENCY; s++) tag_q[s] <= '0;
        end else begin
            if (issue) ptr <= gidx;
            tag_q[1] <= tag_in;
            for (int s = 2; s <= CORE_LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Core output is meaningful only when the last tag stage is valid
    assign push = tag_q[CORE_LATENCY].valid;
    assign pop  = RES_VALID && RES_READY;
    assign unused_tag_id = tag_q[CORE_LATENCY].id >> IDW;

    always_comb begin
        push_entry      = '0;
        push_entry.id   = tag_q[CORE_LATENCY].id[IDW-1:0];
        push_entry.data = core_dout;
`ifdef ANTILOG2_ARB_SAT_EN
        push_entry.sat  = tag_q[CORE_LATENCY].sat;
        if (tag_q[CORE_LATENCY].sat) push_entry.data = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> ({1'b0, fifo_count} < DEPTH_C));

    assign head      = mem[rd_ptr];
    assign RES_VALID = (fifo_count != '0);
    assign RES_DATA  = RES_VALID ? head.data : '0;
    assign RES_ID    = RES_VALID ? head.id : '0;
`ifdef ANTILOG2_ARB_SAT_EN
    assign RES_SAT   = RES_VALID ? head.sat : 1'b0;
`else
    assign RES_SAT   = 1'b0;
`endif
    assign BUSY      = (inflight != 2'd0) || (fifo_count != '0);
endmodule

// File: tb/tb_antilog2_arbiter.sv
// Directed scoreboard bench for antilog2_arbiter (N_REQ=4, DOUT_WIDTH=8, FIFO_DEPTH=4).
module tb_antilog2_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    REQ_VALID;
    logic [12*N-1:0] REQ_DATA;
    logic [N-1:0]    REQ_READY;
    logic            RES_VALID;
    logic            RES_READY;
    logic [DW-1:0]   RES_DATA;
    logic [1:0]      RES_ID;
    logic            RES_SAT;
    logic            BUSY;

    antilog2_arbiter #(.N_REQ(N), .DOUT_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DATA  (RES_DATA),
        .RES_ID    (RES_ID),
        .RES_SAT   (RES_SAT),
        .BUSY      (BUSY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
        logic          sat;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] exp_res [N];
    logic          exp_sat [N];
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [11:0] d, input logic [DW-1:0] r, input logic s);
        REQ_DATA[12*i +: 12] = d;
        exp_res[i] = r;
        exp_sat[i] = s;
    endtask

    task automatic count_grants(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (|(REQ_VALID & REQ_READY)) cnt++;
        end
    endtask

    task automatic wait_grants(input int n, input int budget, output int cnt);
        cnt = 0;
        for (int k = 0; k < budget && cnt < n; k++) begin
            @(negedge clk);
            if (|(REQ_VALID & REQ_READY)) cnt++;
        end
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!BUSY && !RES_VALID) done = 1'b1;
        end
        chk(name, done, 1'b1);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // Scoreboard: expectations pushed on every observed issue, popped on every accepted result
    always @(negedge clk) begin
        if (!rst) begin
            if (RES_VALID && RES_READY) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL res_unexpected: got data=%0d id=%0d, expected no result", RES_DATA, RES_ID);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", RES_DATA, e.data);
                    chk("res_id", RES_ID, e.id);
                    chk("res_sat", RES_SAT, e.sat);
                end
            end
            for (int i = 0; i < N; i++)
                if (REQ_VALID[i] && REQ_READY[i]) sb.push_back('{exp_res[i], i, exp_sat[i]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lat;
        rst = 1'b1;
        REQ_VALID = '1;
        REQ_DATA = '0;
        RES_READY = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_res[i] = '0;
            exp_sat[i] = 1'b0;
        end

        // Reset state, with requests held to show grants are suppressed
        tick();
        @(negedge clk);
        chk("rst_req_ready", REQ_READY, 0);
        chk("rst_res_valid", RES_VALID, 0);
        chk("rst_res_data", RES_DATA, 0);
        chk("rst_res_id", RES_ID, 0);
        chk("rst_res_sat", RES_SAT, 0);
        chk("rst_busy", BUSY, 0);
        tick();
        rst = 1'b0;
        REQ_VALID = '0;

        // Round robin with all four requesters, one grant per cycle
        tick();
        set_req(0, 12'h040, 8'd2, 1'b0);
        set_req(1, 12'h0A0, 8'd5, 1'b0);
        set_req(2, 12'h080, 8'd4, 1'b0);
        set_req(3, 12'h1C0, 8'd128, 1'b0);
        RES_READY = 1'b1;
        REQ_VALID = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k), REQ_READY, 4'b0001 << (k % 4));
            tick();
        end
        REQ_VALID = '0;
        wait_idle("rr_drain");

        // Backpressure: credit caps outstanding work at FIFO depth
        tick();
        RES_READY = 1'b0;
        REQ_VALID = 4'hF;
        count_grants(10, cnt);
        chk("bp_grants", cnt, 4);
        chk("bp_ready_held", REQ_READY, 0);
        tick();
        REQ_VALID = '0;
        RES_READY = 1'b1;
        wait_idle("bp_drain");

        // Integer part at DOUT_WIDTH
        tick();
`ifdef ANTILOG2_ARB_SAT_EN
        set_req(1, 12'h200, 8'd255, 1'b1);
`else
        set_req(1, 12'h200, 8'd0, 1'b0);
`endif
        REQ_VALID = 4'b0010;
        wait_grants(1, 8, cnt);
        chk("sat_grant", cnt, 1);
        tick();
        REQ_VALID = '0;
        wait_idle("sat_drain");

        // Single request, requester 2, issue-to-result latency
        tick();
        set_req(2, 12'h000, 8'd1, 1'b0);
        REQ_VALID = 4'b0100;
        @(negedge clk);
        chk("single_grant", REQ_READY, 4'b0100);
        tick();
        REQ_VALID = '0;
        lat = 0;
        for (int k = 0; k < 8 && !RES_VALID; k++) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", lat, 3);
        wait_idle("single_drain");

        // Reset with two tags in flight and two FIFO entries
        tick();
        set_req(1, 12'h0A0, 8'd5, 1'b0);
        set_req(2, 12'h080, 8'd4, 1'b0);
        RES_READY = 1'b0;
        REQ_VALID = 4'hF;
        wait_grants(4, 12, cnt);
        chk("mid_rst_grants", cnt, 4);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", REQ_READY, 0);
        chk("mid_rst_pre_valid", RES_VALID, 1);
        tick();
        rst = 1'b0;
        REQ_VALID = '0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_res_valid", RES_VALID, 0);
        chk("mid_rst_res_data", RES_DATA, 0);
        chk("mid_rst_res_id", RES_ID, 0);
        chk("mid_rst_busy", BUSY, 0);
        tick();
        RES_READY = 1'b1;
        REQ_VALID = 4'hF;
        @(negedge clk);
        chk("mid_rst_first_grant", REQ_READY, 4'b0001);
        tick();
        REQ_VALID = '0;
        wait_idle("mid_rst_drain");

        // Push and pop together with FIFO at depth-1
        tick();
        RES_READY = 1'b0;
        REQ_VALID = 4'hF;
        wait_grants(3, 10, cnt);
        chk("pp_fill", cnt, 3);
        tick();
        REQ_VALID = '0;
        repeat (4) tick();
        REQ_VALID = 4'b0001;
        @(negedge clk);
        chk("pp_grant", REQ_READY, 4'b0001);
        tick();
        REQ_VALID = '0;
        tick();
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        tick();
        REQ_VALID = 4'hF;
        count_grants(6, cnt);
        chk("pp_credit_left", cnt, 1);
        tick();
        REQ_VALID = '0;
        RES_READY = 1'b1;
        wait_idle("pp_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
